// File: rtl/ld_trig_gen_if.sv
// Purpose: control/status bundle between the register bank and ld_trig_gen.
// Latency: wires only; timing is defined by the modules on either side.
// Backpressure: none; configuration is level-held, cfg_load/start are one-cycle strobes.
// Ports: en/mode/start/burst_len run control; period/width/ch_delay/cfg_load
//        shadow configuration; trig_out/frame_start/busy/pulse_cnt status.
interface ld_trig_gen_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32,
  parameter int DLY_W = 16
);
  logic                    en;
  logic                    mode;
  logic                    start;
  logic [15:0]             burst_len;
  logic [CNT_W-1:0]        period;
  logic [DLY_W-1:0]        width;
  logic [N_CH*DLY_W-1:0]   ch_delay;
  logic                    cfg_load;
  logic [N_CH-1:0]         trig_out;
  logic                    frame_start;
  logic                    busy;
  logic [31:0]             pulse_cnt;

  // Register bank side.
  modport master (
    output en, mode, start, burst_len, period, width, ch_delay, cfg_load,
    input  trig_out, frame_start, busy, pulse_cnt
  );

  // Trigger generator side.
  modport slave (
    input  en, mode, start, burst_len, period, width, ch_delay, cfg_load,
    output trig_out, frame_start, busy, pulse_cnt
  );
endinterface

// File: rtl/ld_trig_gen.sv
// Purpose: period counter driving N_CH delayed laser-diode trigger pulses, continuous or counted burst.
// Latency: RUN entered one clk after en/start; trig_out updates on the falling edge after the counter.
// Backpressure: none; start while busy is dropped, cfg_load is held pending until a safe point.
// Ports: clk, rst_n (async active-low); bus = ld_trig_gen_if.slave carrying
//        run control, shadow configuration inputs and trigger/status outputs.
module ld_trig_gen #(
  parameter int          N_CH       = 2,
  parameter int          CNT_W      = 32,
  parameter int          DLY_W      = 16,
  parameter int unsigned DEF_PERIOD = 1250,
  parameter int unsigned DEF_WIDTH  = 6
) (
  input logic          clk,
  input logic          rst_n,
  ld_trig_gen_if.slave bus
);
  // Pulse window ends are computed one bit wider than the counter so that
  // 1 + delay + width can never wrap around.
  localparam int               XW         = CNT_W + 1;
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_STOP = 2'd2} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]            period_s_q, period_s_d;
  logic [DLY_W-1:0]            width_s_q, width_s_d;
  logic [N_CH-1:0][DLY_W-1:0]  delay_s_q, delay_s_d;
  logic                        pend_q, pend_d;
  logic                        burst_q, burst_d;
  logic [15:0]                 rem_q, rem_d;
  logic [31:0]                 pulse_cnt_q, pulse_cnt_d;
  logic                        frame_q, frame_d;
  logic                        busy_q, busy_d;
  logic [N_CH-1:0]             trig_q, trig_d;
  logic [N_CH-1:0][XW-1:0]     win_lo, win_hi;
  logic                        wrap, apply;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_s_d  = period_s_q;
    width_s_d   = width_s_q;
    delay_s_d   = delay_s_q;
    burst_d     = burst_q;
    rem_d       = rem_q;
    pulse_cnt_d = pulse_cnt_q;

    wrap = (state_q != S_IDLE) && (cnt_q == period_s_q);

    // Shadow update only in IDLE or exactly at a wrap, so a period never
    // sees its geometry change. A load arriving on the wrap cycle is used
    // immediately for the period that starts there.
    if (state_q == S_IDLE) begin
      apply  = pend_q;
      pend_d = bus.cfg_load;
    end else if (wrap) begin
      apply  = pend_q | bus.cfg_load;
      pend_d = 1'b0;
    end else begin
      apply  = 1'b0;
      pend_d = pend_q | bus.cfg_load;
    end

    if (apply) begin
      period_s_d = (bus.period < MIN_PERIOD) ? MIN_PERIOD : bus.period;
      width_s_d  = bus.width;
      for (int i = 0; i < N_CH; i++) begin
        delay_s_d[i] = bus.ch_delay[i*DLY_W +: DLY_W];
      end
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.en && !bus.mode) begin
          state_d = S_RUN;
          burst_d = 1'b0;
        end else if (bus.en && bus.start) begin
          state_d = S_RUN;
          burst_d = 1'b1;
          rem_d   = (bus.burst_len == 16'd0) ? 16'd1 : bus.burst_len;
        end
      end
      S_RUN, S_STOP: begin
        if (wrap) begin
          cnt_d       = '0;
          pulse_cnt_d = pulse_cnt_q + 32'd1;
          if (burst_q) begin
            rem_d = rem_q - 16'd1;
          end
          // en low on the wrap cycle itself ends the run here: the period
          // that just finished was complete.
          if (state_q == S_STOP || !bus.en || (burst_q && rem_q == 16'd1)) begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!bus.en) begin
            state_d = S_STOP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    frame_d = (state_d == S_RUN) && (cnt_d == '0);
  end

  // Channel i is high for counter in [1+delay, 1+delay+width). Counter 0
  // (the wrap) is outside every window, which gives the clamp at wrap.
  always_comb begin
    trig_d = '0;
    win_lo = '0;
    win_hi = '0;
    for (int i = 0; i < N_CH; i++) begin
      win_lo[i] = XW'(delay_s_q[i]) + XW'(1);
      win_hi[i] = win_lo[i] + XW'(width_s_q);
      trig_d[i] = (state_q != S_IDLE) &&
                  (XW'(cnt_q) >= win_lo[i]) && (XW'(cnt_q) < win_hi[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      period_s_q  <= CNT_W'(DEF_PERIOD);
      width_s_q   <= DLY_W'(DEF_WIDTH);
      delay_s_q   <= '0;
      pend_q      <= 1'b0;
      burst_q     <= 1'b0;
      rem_q       <= '0;
      pulse_cnt_q <= '0;
      frame_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_s_q  <= period_s_d;
      width_s_q   <= width_s_d;
      delay_s_q   <= delay_s_d;
      pend_q      <= pend_d;
      burst_q     <= burst_d;
      rem_q       <= rem_d;
      pulse_cnt_q <= pulse_cnt_d;
      frame_q     <= frame_d;
      busy_q      <= busy_d;
    end
  end

  // Falling-edge output stage: half a cycle of settling for the window
  // compare, and the reset clears the pins without waiting for a clock.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= '0;
    end else begin
      trig_q <= trig_d;
    end
  end

  assign bus.trig_out    = trig_q;
  assign bus.frame_start = frame_q;
  assign bus.busy        = busy_q;
  assign bus.pulse_cnt   = pulse_cnt_q;
endmodule

// File: tb/tb_ld_trig_gen.sv
// Purpose: self-checking bench for ld_trig_gen with a period-level reference model.
// Latency: outputs compared once per cycle, after the falling edge.
// Backpressure: not applicable; the bench drives strobes and levels directly.
module tb_ld_trig_gen;
  localparam int N_CH  = 2;
  localparam int CNT_W = 32;
  localparam int DLY_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ld_trig_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W), .DLY_W(DLY_W)) bus();

  ld_trig_gen #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DLY_W(DLY_W),
    .DEF_PERIOD(1250), .DEF_WIDTH(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: where we are inside the current period (m_pos), whether
  // a run is active, and the configuration the running period uses.
  bit        m_act, m_stop, m_burst, m_pend;
  int        m_rem;
  longint    m_pos, m_per, m_wid;
  longint    m_dly[N_CH];
  bit [31:0] m_pc;

  task automatic m_load();
    m_per = (bus.period < 2) ? 2 : longint'(bus.period);
    m_wid = longint'(bus.width);
    for (int i = 0; i < N_CH; i++) m_dly[i] = longint'(bus.ch_delay[i*DLY_W +: DLY_W]);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_stop = 0; m_burst = 0; m_pend = 0; m_rem = 0;
      m_pos = 0; m_per = 1250; m_wid = 6; m_pc = 0;
      for (int i = 0; i < N_CH; i++) m_dly[i] = 0;
    end else begin
      bit wrap;
      wrap = m_act && (m_pos == m_per);
      // configuration: only between runs or at the period boundary
      if (!m_act) begin
        if (m_pend) m_load();
        m_pend = bus.cfg_load;
      end else if (wrap) begin
        if (m_pend || bus.cfg_load) m_load();
        m_pend = 0;
      end else begin
        m_pend = m_pend | bus.cfg_load;
      end
      // sequencing
      if (!m_act) begin
        if (bus.en && (!bus.mode || bus.start)) begin
          m_act = 1; m_stop = 0; m_pos = 0; m_burst = bus.mode;
          m_rem = (bus.burst_len == 0) ? 1 : int'(bus.burst_len);
        end
      end else if (wrap) begin
        m_pc++;
        m_pos = 0;
        if (m_stop || !bus.en || (m_burst && m_rem == 1)) m_act = 0;
        m_rem--;
      end else begin
        m_pos++;
        if (!bus.en) m_stop = 1;
      end
    end
  end

  function automatic logic [35:0] m_expect();
    logic [N_CH-1:0] t;
    t = '0;
    for (int i = 0; i < N_CH; i++)
      t[i] = m_act && (m_pos >= 1 + m_dly[i]) && (m_pos < 1 + m_dly[i] + m_wid);
    return {m_act && (m_pos == 0), m_act, m_pc, t};
  endfunction

  always @(negedge clk) begin
    #2;
    if (rst_n)
      chk("cycle_outputs{frame,busy,pulse_cnt,trig}",
          {bus.frame_start, bus.busy, bus.pulse_cnt, bus.trig_out}, m_expect());
  end

  // Measurement helpers for the hand-computed expectations.
  int n_fr, n_t0, n_t1, n_busy, f_fr, l_fr, f_t0, f_t1, idx;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    n_fr = 0; n_t0 = 0; n_t1 = 0; n_busy = 0; idx = 0;
    f_fr = -1; l_fr = -1; f_t0 = -1; f_t1 = -1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      idx++;
      if (bus.frame_start) begin n_fr++; if (f_fr < 0) f_fr = idx; l_fr = idx; end
      if (bus.trig_out[0]) begin n_t0++; if (f_t0 < 0) f_t0 = idx; end
      if (bus.trig_out[1]) begin n_t1++; if (f_t1 < 0) f_t1 = idx; end
      if (bus.busy) n_busy++;
    end
  endtask

  task automatic cfg(input int per, input int wid, input int d0, input int d1);
    bus.period   = CNT_W'(per);
    bus.width    = DLY_W'(wid);
    bus.ch_delay = {DLY_W'(d1), DLY_W'(d0)};
  endtask

  task automatic load_and_go();
    bus.cfg_load = 1'b1; run(1);
    bus.cfg_load = 1'b0; bus.en = 1'b1; run(1);
  endtask

  task automatic idle_wait(input int max);
    int k;
    k = 0;
    bus.en = 1'b0;
    while (bus.busy && k < max) begin step(); k++; end
    chk("idle_wait_busy", bus.busy, 0);
  endtask

  initial begin
    bus.en = 0; bus.mode = 0; bus.start = 0; bus.burst_len = 0;
    bus.period = 0; bus.width = 0; bus.ch_delay = 0; bus.cfg_load = 0;
    clr();
    #12;
    chk("reset_trig", bus.trig_out, 0);
    chk("reset_frame", bus.frame_start, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_pulse_cnt", bus.pulse_cnt, 0);
    #11 rst_n = 1'b1;
    step();

    // defaults: period 1250, width 6, delay 0
    bus.en = 1'b1; run(1);
    chk("entry_frame", bus.frame_start, 1);
    chk("entry_busy", bus.busy, 1);
    clr(); run(1251);
    chk("def_t0_high_cycles", n_t0, 6);
    chk("def_t0_first", f_t0, 1);
    chk("def_frame_at_1251", f_fr, 1251);
    run(2502);
    chk("def_frames_3", n_fr, 3);
    chk("def_pulse_cnt_3", bus.pulse_cnt, 3);
    idle_wait(1300);

    // period 99, width 10, delays 0 and 40
    cfg(99, 10, 0, 40); load_and_go();
    chk("p99_entry_frame", bus.frame_start, 1);
    clr(); run(100);
    chk("p99_t0_cycles", n_t0, 10);
    chk("p99_t0_first", f_t0, 1);
    chk("p99_t1_cycles", n_t1, 10);
    chk("p99_t1_first", f_t1, 41);
    chk("p99_frame_at_100", f_fr, 100);

    // en dropped at count 5: the pulse and period still complete
    clr(); run(5); bus.en = 1'b0; run(115);
    chk("stop_t0_cycles", n_t0, 10);
    chk("stop_busy_cycles", n_busy, 99);
    chk("stop_idle", bus.busy, 0);

    // burst of 4 with an ignored second start
    bus.mode = 1'b1; bus.burst_len = 16'd4; bus.en = 1'b1; bus.start = 1'b1;
    clr(); run(1); bus.start = 1'b0; run(199);
    bus.start = 1'b1; run(1); bus.start = 1'b0; run(249);
    chk("burst4_busy_cycles", n_busy, 400);
    chk("burst4_frames", n_fr, 4);
    chk("burst4_end_idle", bus.busy, 0);
    bus.burst_len = 16'd0; bus.start = 1'b1;
    clr(); run(1); bus.start = 1'b0; run(149);
    chk("burst0_busy_cycles", n_busy, 100);
    chk("burst0_frames", n_fr, 1);

    // cfg_load at count 20 shortens the period from the next wrap
    bus.mode = 1'b0; run(1); run(20);
    clr(); bus.period = CNT_W'(49); bus.cfg_load = 1'b1; run(1);
    bus.cfg_load = 1'b0; run(229);
    chk("reload_frames", n_fr, 4);
    chk("reload_first_frame", f_fr, 80);
    chk("reload_last_frame", l_fr, 230);
    idle_wait(200);

    // delay 60 beyond period 49 is silent; width past the period clamps at wrap
    cfg(49, 40, 20, 60); load_and_go();
    clr(); run(50);
    chk("clamp_t0_cycles", n_t0, 29);
    chk("clamp_t0_first", f_t0, 21);
    chk("silent_t1_cycles", n_t1, 0);
    idle_wait(200);

    // period 1 behaves as period 2
    cfg(1, 1, 0, 0); load_and_go();
    clr(); run(9);
    chk("p1_frames", n_fr, 3);
    chk("p1_first_frame", f_fr, 3);
    chk("p1_t0_cycles", n_t0, 3);
    idle_wait(100);

    // randomized control and configuration traffic
    bus.en = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfg(int'($urandom_range(0, 30)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 35)), int'($urandom_range(0, 35)));
        bus.cfg_load = 1'b1;
      end else begin
        bus.cfg_load = 1'b0;
      end
      if ($urandom_range(0, 29) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 99) == 0) bus.mode = ~bus.mode;
      bus.start = ($urandom_range(0, 19) == 0);
      bus.burst_len = 16'($urandom_range(0, 3));
      run(1);
    end
    bus.cfg_load = 1'b0; bus.start = 1'b0; bus.mode = 1'b0;
    idle_wait(100);

    // asynchronous reset in the middle of a pulse
    cfg(99, 10, 0, 0); load_and_go();
    run(3);
    chk("pre_reset_t0_high", bus.trig_out[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_trig", bus.trig_out, 0);
    chk("async_reset_busy", bus.busy, 0);
    chk("async_reset_frame", bus.frame_start, 0);
    chk("async_reset_pulse_cnt", bus.pulse_cnt, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    step();
    chk("post_reset_idle", bus.busy, 0);
    run(1);
    chk("post_reset_entry_frame", bus.frame_start, 1);
    clr(); run(1251);
    chk("post_reset_t0_cycles", n_t0, 6);
    chk("post_reset_t0_first", f_t0, 1);
    chk("post_reset_frame_at_1251", f_fr, 1251);
    chk("post_reset_pulse_cnt", bus.pulse_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ld_trig_gen.md
# ld_trig_gen

Multi-channel laser-diode trigger generator for the ADC front end. A single programmable period counter drives N independent trigger outputs, each with its own start delay and a shared pulse width. The block supports continuous and counted-burst modes, shadow-registered configuration and a per-period frame strobe. It sits between the control register bank and the LD driver pins, alongside the AD9234 capture path.

## Interface
- N_CH, 2, number of trigger channels (1..8)
- CNT_W, 32, period counter width
- DLY_W, 16, per-channel delay and pulse width field width
- DEF_PERIOD, 1250, period terminal count loaded at reset
- DEF_WIDTH, 6, pulse width loaded at reset
---
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable, level-sensitive
- mode  in  1  0 = continuous, 1 = burst
- start  in  1  one-cycle burst start strobe, used only when mode=1
- burst_len  in  16  number of periods per burst; 0 is treated as 1
- period  in  CNT_W  terminal count; one period lasts period+1 cycles
- width  in  DLY_W  pulse high time in cycles; 0 disables pulses
- ch_delay  in  N_CH*DLY_W  per-channel delay, channel i at [i*DLY_W +: DLY_W]
- cfg_load  in  1  one-cycle strobe that requests a shadow configuration update
- trig_out  out  N_CH  trigger pulses, registered on the falling edge of clk
- frame_start  out  1  one-cycle strobe, high while counter == 0 in RUN
- busy  out  1  high in RUN and STOP
- pulse_cnt  out  32  number of completed periods since reset, wraps modulo 2^32

## Operation
- Shadow registers hold period_s, width_s and delay_s[i]. Reset values are DEF_PERIOD, DEF_WIDTH and 0.
- cfg_load is captured into a pending flag. The pending flag is applied in IDLE on the next cycle, or in RUN at the cycle where the counter wraps from period_s to 0. This prevents mid-period changes.
- period_s values below 2 are clamped to 2 when loaded.
- FSM states:
  - IDLE: counter held at 0.
    - mode=0 and en=1: go to RUN.
    - mode=1 and start=1 and en=1: go to RUN with burst_rem = max(burst_len,1).
  - RUN: counter increments each cycle and wraps at period_s.
    - On each wrap: pulse_cnt +1; in burst mode burst_rem −1.
    - burst_rem reaching 0: go to IDLE at that wrap.
    - en deasserted: go to STOP.
  - STOP: the current period completes, then the block goes to IDLE at the wrap. Pulses are never truncated by en.
- Channel i goes high when counter == 1 + delay_s[i]. It goes low when counter == 1 + delay_s[i] + width_s, or at wrap, whichever comes first.
- Pulse end arithmetic is evaluated at CNT_W+1 bits, so there is no overflow.
- A channel with 1 + delay_s[i] > period_s never pulses.
- start while busy is ignored. start with mode=0 is ignored.

## Timing
- Reset values: trig_out=0, frame_start=0, busy=0, pulse_cnt=0; FSM in IDLE, counter=0, pending flag clear.
- Rising edge N enters RUN: counter=0, frame_start=1 and busy=1 from edge N.
- trig_out[i] rises on the falling edge after the rising edge where counter becomes 1 + delay_i. It is high for exactly width_s cycles, subject to the wrap clamp.
- frame_start recurs every period_s+1 cycles.
- pulse_cnt increments on the rising edge where the counter wraps.
- Asynchronous reset mid-pulse forces trig_out low immediately, with no glitch on release.
- If cfg_load and a wrap occur in the same cycle, the new values take effect for the period starting at that wrap.

## Test plan
- Reset defaults, mode=0, en=1, delay0=0 -> trig_out[0] high 6 cycles starting at counter=1, frame_start every 1251 cycles, pulse_cnt=3 after 3 periods.
- N_CH=2, period=99, width=10, delays 0 and 40 -> ch0 high at counts 1–10, ch1 high at counts 41–50, repeating every 100 cycles.
- Burst: mode=1, burst_len=4, start -> exactly 4 periods, busy falls at 4th wrap. A second start mid-burst is ignored. burst_len=0 gives exactly 1 period.
- en dropped at count 5, width=10 -> pulse completes 10 cycles, IDLE at wrap, no truncation.
- cfg_load at count 20 changing period 99→49 -> current period stays 100 cycles, the next is 50. delay=60 with period 49 -> channel silent. width reaching past period -> low at wrap. period=1 -> clamped to 2.
- rst_n asserted mid-pulse -> trig_out=0 asynchronously, all outputs at reset values, defaults restored.
